pe_accum_ctrl: RTL and testbench
================================

# pe_accum_ctrl

Sequencing controller for the PE adder tree's accumulation loop. It drives the adder's `previous_sum` input from an internal 20-bit accumulator. It accepts one PE sum per cycle over a valid/ready handshake and counts a configured number of partial-sum beats. It then presents the final accumulated value on a registered valid/ready output port. It sits between the PE array's adder stage and the output buffer, and is programmed once per output pixel/tile by the layer scheduler.

## Interface
- `SUM_W`, default 20: accumulator/PE sum width; must equal the adder's `PE_sum` width.
- `LEN_W`, default 8: width of the beat-count configuration field.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `clr`  in  1  synchronous soft abort; returns to IDLE and clears all state.
- `cfg_valid`  in  1  configuration request.
- `cfg_len`  in  LEN_W  number of partial-sum beats per result, 1..2^LEN_W-1.
- `cfg_ready`  out  1  configuration accepted when `cfg_valid && cfg_ready`.
- `in_valid`  in  1  `pe_sum` beat valid.
- `pe_sum`  in  SUM_W  adder result (`PE_sum`), which already includes `previous_sum`.
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`.
- `previous_sum`  out  SUM_W  accumulator value fed to the adder's `previous_sum` input.
- `out_valid`  out  1  final sum valid.
- `out_sum`  out  SUM_W  final accumulated value, registered.
- `out_ready`  in  1  downstream accepts when `out_valid && out_ready`.
- `busy`  out  1  high in ACCUM or DRAIN.
- `beat_cnt`  out  LEN_W  beats accepted in the current job.

## Operation
- FSM states: IDLE, ACCUM, DRAIN.
- IDLE:
  - `cfg_ready=1`, `in_ready=0`, `out_valid=0`, `acc=0`.
  - A handshake with `cfg_len!=0` latches `len`, clears `beat_cnt`, and moves to ACCUM.
  - A handshake with `cfg_len==0` is consumed with no effect; the FSM stays in IDLE.
- ACCUM:
  - `in_ready=1`, `cfg_ready=0`, `previous_sum=acc`.
  - Each accepted beat sets `acc <= pe_sum` and increments `beat_cnt`.
  - The first beat sees `previous_sum=0`.
  - When the accepted beat makes `beat_cnt==len`: load `out_sum <= pe_sum`, set `acc <= 0`, and go to DRAIN.
- DRAIN:
  - `out_valid=1`, `in_ready=0`, `cfg_ready=0`.
  - `out_sum` holds stable until `out_ready`.
  - On handshake: go to IDLE, `out_valid` falls, `beat_cnt <= 0`.
- Arithmetic:
  - The accumulator is loaded, never added internally; the adder performs the sum.
  - Wrap-around is modulo 2^SUM_W in two's complement. There is no saturation or overflow flag.
- `previous_sum` is combinational from `acc` only. It does not depend on `pe_sum`, so there is no combinational loop through the adder.
- `clr` has priority over every handshake in the same cycle:
  - The FSM returns to IDLE; `acc`, `beat_cnt` and `out_sum` are cleared; `out_valid` drops the next cycle.
  - A beat or config presented in the same cycle is dropped.
- `in_valid` outside ACCUM and `cfg_valid` outside IDLE are ignored; the corresponding ready is low.

## Timing
- Reset values (async on `rst_n` low):
  - State IDLE.
  - `cfg_ready=1`, `in_ready=0`, `out_valid=0`, `busy=0`.
  - `out_sum=0`, `previous_sum=0`, `beat_cnt=0`.
- Reset asserted mid-job discards the job immediately. After release the block is in IDLE.
- Config handshake at cycle t: `in_ready=1` from cycle t+1.
- Throughput is 1 beat/cycle in ACCUM; a job of `len` beats with continuous `in_valid` occupies `len` cycles.
- Last beat accepted at cycle t: `out_valid=1` at t+1. With `out_ready` held high, `cfg_ready=1` again at t+2.
- Minimum job period is `len+2` cycles (config, `len` beats, drain).
- `previous_sum` updates the cycle after each accepted beat, so the adder sees the new accumulator on the next beat.
- Backpressure (`out_ready=0`) holds DRAIN indefinitely with `out_sum` stable. No beats are accepted meanwhile.
- `in_valid` gaps in ACCUM stall: `acc` and `beat_cnt` hold and `previous_sum` is stable.

## Test plan
- Reset/idle: assert `rst_n=0` mid-ACCUM with `beat_cnt=3` -> all outputs at reset values within the same cycle; after release `cfg_ready=1` and `previous_sum=0`.
- Basic job: `cfg_len=4`; bench model adds `0x00010+previous_sum` per beat -> `previous_sum` sequence 0, 0x10, 0x20, 0x30; `out_sum=0x00040`; `out_valid` the cycle after the 4th beat.
- Signed and wrap: `cfg_len=2`; beats 0xFFFFF (-1) then 0x7FFFF + previous_sum -> `out_sum=0x7FFFE`. Then a job summing past 0x7FFFF wraps modulo 2^20 with no flag.
- Backpressure and stalls: `cfg_len=3`; `in_valid` toggling 1,0,1,0,1; `out_ready` low for 5 cycles -> exactly 3 beats counted, `out_sum` stable through all 5 cycles, a single output handshake.
- Corner configs: `cfg_len=0` -> stays IDLE, no `busy`. `cfg_len=255` -> 255 beats, `beat_cnt` reaches 255, correct sum. `cfg_valid` while busy is ignored.
- Soft clear: `clr` pulsed in ACCUM after 2 beats, coincident with an `in_valid` beat -> beat dropped, IDLE next cycle, `previous_sum=0`. A following `cfg_len=1` job yields `out_sum` equal to the single beat.

Source files
------------

// File: rtl/pe_accum_ctrl_if.sv
// ---------------------------------------------------------------------------
// pe_accum_ctrl_if
// Bundles the control, configuration, beat-input and result-output signals
// of the PE accumulation controller.
//   master : scheduler / adder / output-buffer side (drives requests)
//   slave  : pe_accum_ctrl (drives readies, accumulator and result)
// Signals:
//   clr                  synchronous soft abort
//   cfg_valid/ready/len  job configuration handshake, len = beats per result
//   in_valid/ready       pe_sum beat handshake
//   pe_sum               adder result, already includes previous_sum
//   previous_sum         accumulator fed back to the adder
//   out_valid/ready      final result handshake, out_sum = result
//   busy, beat_cnt       status
// ---------------------------------------------------------------------------
interface pe_accum_ctrl_if #(
    parameter int SUM_W = 20,
    parameter int LEN_W = 8
);
    logic             clr;
    logic             cfg_valid;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_ready;
    logic             in_valid;
    logic [SUM_W-1:0] pe_sum;
    logic             in_ready;
    logic [SUM_W-1:0] previous_sum;
    logic             out_valid;
    logic [SUM_W-1:0] out_sum;
    logic             out_ready;
    logic             busy;
    logic [LEN_W-1:0] beat_cnt;

    modport master (
        output clr, cfg_valid, cfg_len, in_valid, pe_sum, out_ready,
        input  cfg_ready, in_ready, previous_sum, out_valid, out_sum, busy, beat_cnt
    );

    modport slave (
        input  clr, cfg_valid, cfg_len, in_valid, pe_sum, out_ready,
        output cfg_ready, in_ready, previous_sum, out_valid, out_sum, busy, beat_cnt
    );
endinterface

// File: rtl/pe_accum_ctrl.sv
// ---------------------------------------------------------------------------
// pe_accum_ctrl
// Sequencing controller for the PE adder tree accumulation loop. A job is
// configured with a beat count; each accepted pe_sum beat is loaded into the
// accumulator (the external adder does the addition using previous_sum).
// After the last beat the result is presented on a registered output port.
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    pe_accum_ctrl_if.slave (config, beat input, result output, status)
// ---------------------------------------------------------------------------
module pe_accum_ctrl #(
    parameter int SUM_W = 20,
    parameter int LEN_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pe_accum_ctrl_if.slave       bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [SUM_W-1:0] r_acc;
    logic [SUM_W-1:0] r_out_sum;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_beat_cnt;

    logic             w_cfg_ready;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_cfg_take;
    logic             w_beat_take;
    logic             w_last_beat;
    logic [LEN_W-1:0] w_cnt_inc;

    assign w_cnt_inc   = r_beat_cnt + 1'b1;
    assign w_cfg_take  = w_cfg_ready && bus.cfg_valid && (bus.cfg_len != '0);
    assign w_beat_take = w_in_ready && bus.in_valid;
    // len is never zero in ACCUM, so the incremented count cannot overflow.
    assign w_last_beat = w_beat_take && (w_cnt_inc == r_len);

    // NOTE: every signal driven in always_comb gets a default first, so no
    // path through the case statement can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_cfg_ready  = 1'b0;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cfg_ready = 1'b1;
                if (bus.cfg_valid && (bus.cfg_len != '0)) w_next_state = ST_ACCUM;
            end
            ST_ACCUM: begin
                w_in_ready = 1'b1;
                if (w_last_beat) w_next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
        // Soft abort wins over any handshake presented in the same cycle.
        if (bus.clr) w_next_state = ST_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_out_sum  <= '0;
            r_len      <= '0;
            r_beat_cnt <= '0;
        end else if (bus.clr) begin
            r_acc      <= '0;
            r_out_sum  <= '0;
            r_len      <= '0;
            r_beat_cnt <= '0;
        end else begin
            if (w_cfg_take) begin
                r_len      <= bus.cfg_len;
                r_beat_cnt <= '0;
                r_acc      <= '0;
            end
            if (w_beat_take) begin
                r_beat_cnt <= w_cnt_inc;
                if (w_last_beat) begin
                    r_out_sum <= bus.pe_sum;
                    r_acc     <= '0;
                end else begin
                    r_acc     <= bus.pe_sum;
                end
            end
            if (w_out_valid && bus.out_ready) begin
                r_beat_cnt <= '0;
            end
        end
    end

    // previous_sum depends on the accumulator register only, which keeps the
    // adder feedback path free of combinational loops.
    assign bus.previous_sum = r_acc;
    assign bus.cfg_ready    = w_cfg_ready;
    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = w_out_valid;
    assign bus.out_sum      = r_out_sum;
    assign bus.busy         = (r_state == ST_ACCUM) || (r_state == ST_DRAIN);
    assign bus.beat_cnt     = r_beat_cnt;

endmodule

// File: tb/tb_pe_accum_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pe_accum_ctrl
// Directed self-checking bench for pe_accum_ctrl. The bench models the
// external adder with its own expected accumulator value and checks the
// controller's outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_pe_accum_ctrl;

    localparam int SUM_W = 20;
    localparam int LEN_W = 8;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_fail;

    logic [SUM_W-1:0] m_acc;     // bench model of the accumulator
    logic [SUM_W-1:0] held_sum;

    pe_accum_ctrl_if #(.SUM_W(SUM_W), .LEN_W(LEN_W)) bus ();

    pe_accum_ctrl #(.SUM_W(SUM_W), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [LEN_W-1:0] len);
        bus.cfg_valid = 1'b1;
        bus.cfg_len   = len;
        tick();
        bus.cfg_valid = 1'b0;
        bus.cfg_len   = '0;
        m_acc         = '0;
    endtask

    // One accepted beat: previous_sum must match the model, then the adder
    // result (model + inc, wrapped) is presented for one cycle.
    task automatic beat(input string tag, input logic [SUM_W-1:0] inc, input bit last);
        logic [SUM_W-1:0] sum;
        check(tag, bus.previous_sum, m_acc);
        sum          = m_acc + inc;
        bus.pe_sum   = sum;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        held_sum     = sum;
        m_acc        = last ? '0 : sum;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        m_acc         = '0;
        held_sum      = '0;
        rst_n         = 1'b0;
        bus.clr       = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_len   = '0;
        bus.in_valid  = 1'b0;
        bus.pe_sum    = '0;
        bus.out_ready = 1'b0;

        // Reset values
        #3;
        check("rst_cfg_ready", bus.cfg_ready, 1);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_out_sum", bus.out_sum, 0);
        check("rst_prev_sum", bus.previous_sum, 0);
        check("rst_beat_cnt", bus.beat_cnt, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic job, len 4, +0x10 per beat
        do_cfg(8'd4);
        check("basic_in_ready", bus.in_ready, 1);
        check("basic_busy", bus.busy, 1);
        check("basic_cfg_ready", bus.cfg_ready, 0);
        beat("basic_prev0", 20'h00010, 1'b0);
        check("basic_prev_exp1", bus.previous_sum, 20'h00010);
        beat("basic_prev1", 20'h00010, 1'b0);
        beat("basic_prev2", 20'h00010, 1'b0);
        check("basic_prev_exp3", bus.previous_sum, 20'h00030);
        beat("basic_prev3", 20'h00010, 1'b1);
        check("basic_out_valid", bus.out_valid, 1);
        check("basic_out_sum", bus.out_sum, 20'h00040);
        check("basic_in_ready_drain", bus.in_ready, 0);
        check("basic_prev_drain", bus.previous_sum, 0);
        check("basic_beat_cnt", bus.beat_cnt, 4);
        drain();
        check("basic_out_valid_low", bus.out_valid, 0);
        check("basic_cfg_ready_back", bus.cfg_ready, 1);
        check("basic_beat_cnt_clr", bus.beat_cnt, 0);

        // Signed: -1 then +0x7FFFF -> 0x7FFFE
        do_cfg(8'd2);
        beat("sign_prev0", 20'hFFFFF, 1'b0);
        beat("sign_prev1", 20'h7FFFF, 1'b1);
        check("sign_out_sum", bus.out_sum, 20'h7FFFE);
        drain();

        // Wrap: 0x70000 * 3 = 0x150000 -> 0x50000 mod 2^20
        do_cfg(8'd3);
        beat("wrap_prev0", 20'h70000, 1'b0);
        beat("wrap_prev1", 20'h70000, 1'b0);
        check("wrap_prev_e0000", bus.previous_sum, 20'hE0000);
        beat("wrap_prev2", 20'h70000, 1'b1);
        check("wrap_out_sum", bus.out_sum, 20'h50000);
        drain();

        // Stalls and backpressure, len 3, in_valid 1,0,1,0,1, +5 per beat
        do_cfg(8'd3);
        beat("stall_prev0", 20'h00005, 1'b0);
        tick();
        check("stall_cnt_hold0", bus.beat_cnt, 1);
        check("stall_prev_hold0", bus.previous_sum, 20'h00005);
        beat("stall_prev1", 20'h00005, 1'b0);
        tick();
        check("stall_cnt_hold1", bus.beat_cnt, 2);
        check("stall_prev_hold1", bus.previous_sum, 20'h0000A);
        beat("stall_prev2", 20'h00005, 1'b1);
        bus.in_valid = 1'b1;
        bus.pe_sum   = 20'h12345;
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_out_sum", bus.out_sum, 20'h0000F);
            check("bp_beat_cnt", bus.beat_cnt, 3);
            tick();
        end
        bus.in_valid = 1'b0;
        drain();
        check("bp_single_handshake", bus.out_valid, 0);
        check("bp_out_sum_after", bus.out_sum, 20'h0000F);
        check("bp_cfg_ready", bus.cfg_ready, 1);

        // cfg_len == 0 is consumed with no effect
        do_cfg(8'd0);
        check("len0_busy", bus.busy, 0);
        check("len0_cfg_ready", bus.cfg_ready, 1);
        check("len0_in_ready", bus.in_ready, 0);

        // cfg_valid while busy is ignored: a len-1 job still ends after 1 beat
        do_cfg(8'd1);
        bus.cfg_valid = 1'b1;
        bus.cfg_len   = 8'd7;
        check("busy_cfg_ready", bus.cfg_ready, 0);
        tick();
        check("busy_beat_cnt", bus.beat_cnt, 0);
        check("busy_still", bus.busy, 1);
        beat("busy_prev0", 20'h00123, 1'b1);
        check("busy_out_valid", bus.out_valid, 1);
        check("busy_out_sum", bus.out_sum, 20'h00123);
        check("busy_cfg_ready_drain", bus.cfg_ready, 0);
        bus.cfg_valid = 1'b0;
        bus.cfg_len   = '0;
        drain();
        check("busy_idle", bus.busy, 0);

        // Maximum length, 255 beats of +1
        do_cfg(8'd255);
        for (int i = 0; i < 254; i++) begin
            beat("max_prev", 20'h00001, 1'b0);
        end
        check("max_cnt_254", bus.beat_cnt, 254);
        check("max_prev_254", bus.previous_sum, 20'h000FE);
        beat("max_prev_last", 20'h00001, 1'b1);
        check("max_beat_cnt", bus.beat_cnt, 255);
        check("max_out_sum", bus.out_sum, 20'h000FF);
        check("max_out_valid", bus.out_valid, 1);
        drain();

        // Soft clear after 2 beats, coincident with a beat
        do_cfg(8'd4);
        beat("clr_prev0", 20'h00011, 1'b0);
        beat("clr_prev1", 20'h00022, 1'b0);
        bus.clr      = 1'b1;
        bus.in_valid = 1'b1;
        bus.pe_sum   = 20'h00999;
        tick();
        bus.clr      = 1'b0;
        bus.in_valid = 1'b0;
        check("clr_cfg_ready", bus.cfg_ready, 1);
        check("clr_busy", bus.busy, 0);
        check("clr_prev_sum", bus.previous_sum, 0);
        check("clr_beat_cnt", bus.beat_cnt, 0);
        check("clr_out_sum", bus.out_sum, 0);
        do_cfg(8'd1);
        beat("clr_job_prev", 20'h00ABC, 1'b1);
        check("clr_job_out_sum", bus.out_sum, 20'h00ABC);
        check("clr_job_out_valid", bus.out_valid, 1);
        drain();

        // Asynchronous reset mid-ACCUM with beat_cnt == 3
        do_cfg(8'd5);
        beat("arst_prev0", 20'h00100, 1'b0);
        beat("arst_prev1", 20'h00100, 1'b0);
        beat("arst_prev2", 20'h00100, 1'b0);
        check("arst_cnt_pre", bus.beat_cnt, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_cfg_ready", bus.cfg_ready, 1);
        check("arst_in_ready", bus.in_ready, 0);
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_out_sum", bus.out_sum, 0);
        check("arst_prev_sum", bus.previous_sum, 0);
        check("arst_beat_cnt", bus.beat_cnt, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_rel_cfg_ready", bus.cfg_ready, 1);
        check("arst_rel_prev_sum", bus.previous_sum, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
